adsr: RTL and testbench

- Per-sample ADSR envelope generator for the synth voice path; one clock = one audio sample.
- Produces an unsigned-magnitude fixed-point gain (0.0 to 1.0) in signed Q(TOTAL_BITS-FRACTIONAL_BITS).FRACTIONAL_BITS format.
- The gain ramps linearly through attack, decay, sustain and release, driven by a gate.
- `active` flags a sounding envelope so the voice allocator can reclaim idle voices.

---
 rtl/adsr_pkg.sv | 18 +
 rtl/adsr.sv | 129 ++++++++++++
 tb/tb_adsr.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/adsr_pkg.sv
// Shared types and helpers for the ADSR envelope generator.
package adsr_pkg;

  // Envelope phase; IDLE is the only silent state.
  typedef enum logic [2:0] {
    StIdle,
    StAttack,
    StDecay,
    StSustain,
    StRelease
  } state_e;

  // Fixed-point representation of 1.0 for a given number of fractional bits.
  function automatic longint unsigned one_of(input int unsigned frac_bits);
    return 64'd1 << frac_bits;
  endfunction

endpackage

// File: rtl/adsr.sv
// Per-sample linear ADSR envelope generator. One clock edge = one audio sample.
// out is an unsigned magnitude in [0, ONE] carried in a signed fixed-point port.
module adsr
  import adsr_pkg::*;
#(
  parameter int unsigned TOTAL_BITS      = 32,
  parameter int unsigned FRACTIONAL_BITS = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [TOTAL_BITS-1:0] a,
  input  logic [TOTAL_BITS-1:0] d,
  input  logic [TOTAL_BITS-1:0] s,
  input  logic [TOTAL_BITS-1:0] r,
  input  logic                  gate,
  output logic [TOTAL_BITS-1:0] out,
  output logic                  active
);

  localparam int unsigned W  = TOTAL_BITS;
  // One guard bit so out + step never wraps before the ONE comparison.
  localparam int unsigned WE = TOTAL_BITS + 1;

  localparam logic [WE-1:0] OneExt = WE'(one_of(FRACTIONAL_BITS));
  localparam logic [W-1:0]  One    = OneExt[W-1:0];

  // Negative signed values are treated as a zero magnitude.
  function automatic logic [WE-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? '0 : {1'b0, v};
  endfunction

  // Saturating subtract that floors at zero instead of wrapping.
  function automatic logic [WE-1:0] sat_sub(input logic [WE-1:0] x, input logic [WE-1:0] y);
    return (y >= x) ? '0 : x - y;
  endfunction

  state_e        state_q;
  logic [W-1:0]  out_q;
  logic          active_q;
  logic          gate_q;

  logic [WE-1:0] a_mag, d_mag, s_mag, r_mag, s_cl;
  logic [WE-1:0] out_ext, att_sum, dec_val, rel_val;
  logic          rise, fall;

  // Ramp arithmetic for every phase, evaluated from the current sample's inputs.
  always_comb begin
    a_mag   = mag(a);
    d_mag   = mag(d);
    s_mag   = mag(s);
    r_mag   = mag(r);
    s_cl    = (s_mag > OneExt) ? OneExt : s_mag;
    out_ext = {1'b0, out_q};
    att_sum = out_ext + a_mag;
    dec_val = sat_sub(out_ext, d_mag);
    rel_val = sat_sub(out_ext, r_mag);
    rise    = gate & ~gate_q;
    fall    = ~gate & gate_q;
  end

  // Envelope FSM: gate edges take precedence over the ramp update in each phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      out_q    <= '0;
      active_q <= 1'b0;
      gate_q   <= 1'b0;
    end else begin
      gate_q <= gate;
      unique case (state_q)
        StIdle: begin
          out_q <= '0;
          if (rise) begin
            state_q  <= StAttack;
            active_q <= 1'b1;
          end
        end
        StAttack: begin
          if (fall) begin
            state_q <= StRelease;
          end else if (att_sum >= OneExt) begin
            out_q   <= One;
            state_q <= StDecay;
          end else begin
            out_q <= att_sum[W-1:0];
          end
        end
        StDecay: begin
          if (fall) begin
            state_q <= StRelease;
          end else if (dec_val <= s_cl) begin
            out_q   <= s_cl[W-1:0];
            state_q <= StSustain;
          end else begin
            out_q <= dec_val[W-1:0];
          end
        end
        StSustain: begin
          if (fall) begin
            state_q <= StRelease;
          end else begin
            out_q <= s_cl[W-1:0];
          end
        end
        StRelease: begin
          // A retrigger ramps up from the current level rather than from zero.
          if (rise) begin
            state_q <= StAttack;
          end else if (rel_val == '0) begin
            out_q    <= '0;
            state_q  <= StIdle;
            active_q <= 1'b0;
          end else begin
            out_q <= rel_val[W-1:0];
          end
        end
        default: begin
          state_q  <= StIdle;
          out_q    <= '0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign out    = out_q;
  assign active = active_q;

endmodule

// File: tb/tb_adsr.sv
// Directed, table-driven bench for the ADSR envelope generator (Q16.16).
module tb_adsr;

  localparam int unsigned TB = 32;
  localparam int unsigned FB = 16;

  logic          clock;
  logic          reset;
  logic [TB-1:0] a, d, s, r;
  logic          gate;
  logic [TB-1:0] out;
  logic          active;

  int n_checks;
  int n_fail;

  adsr #(
    .TOTAL_BITS     (TB),
    .FRACTIONAL_BITS(FB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .a     (a),
    .d     (d),
    .s     (s),
    .r     (r),
    .gate  (gate),
    .out   (out),
    .active(active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string         name;
    logic          gate;
    logic [TB-1:0] a;
    logic [TB-1:0] d;
    logic [TB-1:0] s;
    logic [TB-1:0] r;
    int            edges;
    logic [TB-1:0] exp_out;
    logic          exp_act;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic g, input logic [TB-1:0] va,
                     input logic [TB-1:0] vd, input logic [TB-1:0] vs, input logic [TB-1:0] vr,
                     input int n, input logic [TB-1:0] eo, input logic ea);
    vec_t v;
    v.name = name; v.gate = g; v.a = va; v.d = vd; v.s = vs; v.r = vr;
    v.edges = n; v.exp_out = eo; v.exp_act = ea;
    vecs.push_back(v);
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [TB-1:0] eo, input logic ea);
    n_checks++;
    if (out !== eo) begin
      n_fail++;
      $display("FAIL %s: out got %0d expected %0d", name, out, eo);
    end
    n_checks++;
    if (active !== ea) begin
      n_fail++;
      $display("FAIL %s: active got %0b expected %0b", name, active, ea);
    end
  endtask

  localparam logic [TB-1:0] P655 = 32'd655;
  localparam logic [TB-1:0] SHALF = 32'd32768;
  localparam logic [TB-1:0] NEG5 = 32'hFFFF_FFFB;
  localparam logic [TB-1:0] BIG = 32'h7FFF_FFFF;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    a = P655; d = P655; s = SHALF; r = P655; gate = 1'b0;

    // Full cycle
    add("rise_to_attack", 1, P655, P655, SHALF, P655, 1, 0, 1);
    add("attack_1", 1, P655, P655, SHALF, P655, 1, 655, 1);
    add("attack_100", 1, P655, P655, SHALF, P655, 99, 65500, 1);
    add("attack_101_one", 1, P655, P655, SHALF, P655, 1, 65536, 1);
    add("decay_1", 1, P655, P655, SHALF, P655, 1, 64881, 1);
    add("decay_50", 1, P655, P655, SHALF, P655, 49, 32786, 1);
    add("decay_51_sus", 1, P655, P655, SHALF, P655, 1, 32768, 1);
    add("sustain_hold", 1, P655, P655, SHALF, P655, 5, 32768, 1);
    add("sustain_live_s", 1, P655, P655, 32'd16384, P655, 1, 16384, 1);
    add("sustain_s_back", 1, P655, P655, SHALF, P655, 1, 32768, 1);
    add("fall_hold", 0, P655, P655, SHALF, P655, 1, 32768, 1);
    add("release_50", 0, P655, P655, SHALF, P655, 50, 18, 1);
    add("release_51_idle", 0, P655, P655, SHALF, P655, 1, 0, 0);
    add("idle_stays", 0, P655, P655, SHALF, P655, 3, 0, 0);
    // Release during attack
    add("rda_rise", 1, P655, P655, SHALF, P655, 1, 0, 1);
    add("rda_attack_20", 1, P655, P655, SHALF, P655, 20, 13100, 1);
    add("rda_fall_hold", 0, P655, P655, SHALF, P655, 1, 13100, 1);
    add("rda_release_19", 0, P655, P655, SHALF, P655, 19, 655, 1);
    add("rda_release_end", 0, P655, P655, SHALF, P655, 1, 0, 0);
    // Retrigger during release
    add("rt_rise", 1, P655, P655, SHALF, P655, 1, 0, 1);
    add("rt_attack_40", 1, P655, P655, SHALF, P655, 40, 26200, 1);
    add("rt_fall_hold", 0, P655, P655, SHALF, P655, 1, 26200, 1);
    add("rt_release_9", 0, P655, P655, SHALF, P655, 9, 20305, 1);
    add("rt_rise_hold", 1, P655, P655, SHALF, P655, 1, 20305, 1);
    add("rt_attack_up", 1, P655, P655, SHALF, P655, 1, 20960, 1);
    // Step and sustain edge cases
    add("neg_attack_holds", 1, NEG5, P655, SHALF, P655, 3, 20960, 1);
    add("big_attack_sat", 1, BIG, P655, SHALF, P655, 1, 65536, 1);
    add("s_one_decay_1", 1, P655, P655, 32'd65536, P655, 1, 65536, 1);
    add("s_one_in_sustain", 1, P655, P655, 32'd16384, P655, 1, 16384, 1);
    add("s_clamp_high", 1, P655, P655, 32'd100000, P655, 1, 65536, 1);
    add("s_clamp_neg", 1, P655, P655, 32'hFFFF_FFFF, P655, 1, 0, 1);
    add("s_restore", 1, P655, P655, SHALF, P655, 1, 32768, 1);
    add("r0_fall_hold", 0, P655, P655, SHALF, 32'd0, 1, 32768, 1);
    add("r0_holds", 0, P655, P655, SHALF, 32'd0, 4, 32768, 1);
    add("big_release_sat", 0, P655, P655, SHALF, BIG, 1, 0, 0);

    // Asynchronous reset with no clock edge involved
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 check("reset_async", 0, 0);
    step(2);
    check("reset_held", 0, 0);
    reset = 1'b1;
    step(3);
    check("idle_after_reset", 0, 0);

    foreach (vecs[i]) begin
      gate = vecs[i].gate;
      a = vecs[i].a; d = vecs[i].d; s = vecs[i].s; r = vecs[i].r;
      step(vecs[i].edges);
      check(vecs[i].name, vecs[i].exp_out, vecs[i].exp_act);
    end

    // Reset mid-attack
    a = P655; d = P655; s = SHALF; r = P655;
    gate = 1'b1;
    step(1);
    step(45);
    check("mid_attack", 29475, 1);
    #2 reset = 1'b0;
    #1 check("reset_mid_attack", 0, 0);
    gate = 1'b0;
    step(2);
    check("reset_mid_held", 0, 0);
    reset = 1'b1;
    step(3);
    check("no_restart_wo_edge", 0, 0);
    gate = 1'b1;
    step(1);
    check("restart_rise", 0, 1);
    step(1);
    check("restart_attack", 655, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
